// File: rtl/serial_operand_loader.sv
// Deserialises the decoder's serial key stream into operand A, optional operand B
// and a 2-bit opcode, then holds them for the ALU under a valid/ready handshake.
module serial_operand_loader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic             mode,
  input  logic             input_key,
  input  logic             valid_cmd,
  input  logic             out_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [1:0]       opcode,
  output logic             unary,
  output logic             out_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_LOAD_OP = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] op_a_r, op_a_s;
  logic [WIDTH-1:0] op_b_r, op_b_s;
  logic [1:0]       opcode_r, opcode_s;
  logic             unary_r, unary_s;
  logic             out_valid_r, out_valid_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             active_d_r;
  logic             armed_r;
  logic             start_s;

  // Next-state and datapath update for the load/hold sequence
  always_comb begin
    state_s     = state_r;
    op_a_s      = op_a_r;
    op_b_s      = op_b_r;
    opcode_s    = opcode_r;
    unary_s     = unary_r;
    out_valid_s = out_valid_r;
    cnt_s       = cnt_r;
    // armed_r keeps an active level held across reset from looking like a fresh edge
    start_s     = active & ~active_d_r & armed_r;

    case (state_r)
      S_IDLE: begin
        if (start_s) begin
          state_s  = S_LOAD_A;
          unary_s  = mode;
          op_a_s   = '0;
          op_b_s   = '0;
          opcode_s = 2'b00;
          cnt_s    = '0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD_A: begin
        if (!active) begin
          state_s = S_IDLE;
          cnt_s   = '0;
        end else if (valid_cmd) begin
          op_a_s = {op_a_r[WIDTH-2:0], input_key};
          if (cnt_r == CW'(WIDTH - 1)) begin
            cnt_s   = '0;
            state_s = unary_r ? S_LOAD_OP : S_LOAD_B;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end else begin
          state_s = S_LOAD_A;
        end
      end
      S_LOAD_B: begin
        if (!active) begin
          state_s = S_IDLE;
          cnt_s   = '0;
        end else if (valid_cmd) begin
          op_b_s = {op_b_r[WIDTH-2:0], input_key};
          if (cnt_r == CW'(WIDTH - 1)) begin
            cnt_s   = '0;
            state_s = S_LOAD_OP;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end else begin
          state_s = S_LOAD_B;
        end
      end
      S_LOAD_OP: begin
        if (!active) begin
          state_s = S_IDLE;
          cnt_s   = '0;
        end else if (valid_cmd) begin
          opcode_s = {opcode_r[0], input_key};
          if (cnt_r == CW'(1)) begin
            cnt_s       = '0;
            state_s     = S_HOLD;
            out_valid_s = 1'b1;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end else begin
          state_s = S_LOAD_OP;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          state_s     = S_IDLE;
        end else begin
          state_s = S_HOLD;
        end
      end
      default: begin
        state_s     = S_IDLE;
        out_valid_s = 1'b0;
        cnt_s       = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      op_a_r      <= '0;
      op_b_r      <= '0;
      opcode_r    <= 2'b00;
      unary_r     <= 1'b0;
      out_valid_r <= 1'b0;
      cnt_r       <= '0;
      active_d_r  <= 1'b0;
      armed_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      op_a_r      <= op_a_s;
      op_b_r      <= op_b_s;
      opcode_r    <= opcode_s;
      unary_r     <= unary_s;
      out_valid_r <= out_valid_s;
      cnt_r       <= cnt_s;
      active_d_r  <= active;
      armed_r     <= armed_r | ~active;
    end
  end

  assign op_a      = op_a_r;
  assign op_b      = op_b_r;
  assign opcode    = opcode_r;
  assign unary     = unary_r;
  assign out_valid = out_valid_r;
  assign busy      = (state_r != S_IDLE);

endmodule

// File: tb/tb_serial_operand_loader.sv
// Randomised self-checking bench for serial_operand_loader; expected operands come
// from the values the bench itself serialises onto the key stream.
module tb_serial_operand_loader;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset, active, mode, input_key, valid_cmd, out_ready;
  logic [WIDTH-1:0] op_a, op_b;
  logic [1:0]       opcode;
  logic             unary, out_valid, busy;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_a, exp_b;
  logic [1:0]       exp_op;
  logic             exp_u;

  always #5 clk = ~clk;

  serial_operand_loader #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .active(active), .mode(mode),
    .input_key(input_key), .valid_cmd(valid_cmd), .out_ready(out_ready),
    .op_a(op_a), .op_b(op_b), .opcode(opcode), .unary(unary),
    .out_valid(out_valid), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_op_a"}, op_a, exp_a);
    check({tag, "_op_b"}, op_b, exp_b);
    check({tag, "_opcode"}, opcode, exp_op);
    check({tag, "_unary"}, unary, exp_u);
  endtask

  task automatic start_txn(input logic m, input logic start_bit);
    active = 1'b0; valid_cmd = 1'b0; tick();
    active = 1'b1; mode = m; valid_cmd = start_bit; input_key = start_bit; tick();
    valid_cmd = 1'b0;
    check("start_busy", busy, 1);
    check("start_clr_a", op_a, 0);
    check("start_clr_b", op_b, 0);
    check("start_unary", unary, m);
  endtask

  // gap_mode: 0 = back-to-back, 1 = one idle cycle per bit, 2 = random idle cycles
  task automatic send(input logic [31:0] val, input int n, input int gap_mode);
    int gaps;
    for (int i = n - 1; i >= 0; i--) begin
      gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        valid_cmd = 1'b0; input_key = 1'($urandom); tick();
        check("gap_busy", busy, 1);
        check("gap_valid", out_valid, 0);
      end
      valid_cmd = 1'b1; input_key = val[i]; tick();
    end
    valid_cmd = 1'b0;
  endtask

  task automatic load(input logic m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [1:0] op, input int gap_mode, input logic start_bit);
    exp_a = 8'h00; exp_b = 8'h00; exp_op = 2'b00; exp_u = m;
    start_txn(m, start_bit);
    send(32'(a), WIDTH, gap_mode);
    check("a_no_valid", out_valid, 0);
    if (!m) begin
      send(32'(b), WIDTH, gap_mode);
      check("b_no_valid", out_valid, 0);
    end
    send(32'(op), 2, gap_mode);
    exp_a = a; exp_b = m ? 8'h00 : b; exp_op = op;
    check("load_valid", out_valid, 1);
    check_outputs("load");
  endtask

  task automatic accept(input int stall, input logic drop_active);
    if (drop_active) active = 1'b0;
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      valid_cmd = 1'($urandom); input_key = 1'($urandom); tick();
      check("hold_valid", out_valid, 1);
      check("hold_busy", busy, 1);
      check_outputs("hold");
    end
    valid_cmd = 1'b0; out_ready = 1'b1; tick();
    check("acc_valid", out_valid, 0);
    check("acc_busy", busy, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; active = 1'b0; mode = 1'b0; input_key = 1'b0;
    valid_cmd = 1'b0; out_ready = 1'b0;
    exp_a = 8'h00; exp_b = 8'h00; exp_op = 2'b00; exp_u = 1'b0;
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check_outputs("rst");
    reset = 1'b1;
    tick();

    // binary directed load
    load(1'b0, 8'hA5, 8'h3C, 2'b10, 0, 1'b0);
    accept(0, 1'b0);

    // unary with alternating gaps, then backpressure
    load(1'b1, 8'h81, 8'h00, 2'b01, 1, 1'b0);
    accept(5, 1'b0);

    // abort after 4 bits of A; out_ready high must not matter
    start_txn(1'b0, 1'b0);
    send(32'hA, 4, 0);
    active = 1'b0; out_ready = 1'b1; tick();
    check("abort_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("abort_valid", out_valid, 0);
    end
    out_ready = 1'b0;
    load(1'b0, 8'hFF, 8'h01, 2'b11, 0, 1'b0);
    accept(1, 1'b0);

    // reset during LOAD_B, active held high afterwards
    start_txn(1'b0, 1'b0);
    send(32'h5A, WIDTH, 0);
    send(32'h5, 3, 0);
    reset = 1'b0; tick();
    exp_a = 8'h00; exp_b = 8'h00; exp_op = 2'b00; exp_u = 1'b0;
    check("mrst_valid", out_valid, 0);
    check("mrst_busy", busy, 0);
    check_outputs("mrst");
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      valid_cmd = 1'b1; input_key = 1'($urandom); tick();
      check("mrst_no_start", busy, 0);
    end
    valid_cmd = 1'b0;
    load(1'b0, 8'h96, 8'h69, 2'b01, 0, 1'b0);
    accept(0, 1'b0);

    // start-cycle bit must not be captured
    load(1'b0, 8'h00, 8'h7E, 2'b00, 0, 1'b1);
    accept(0, 1'b0);

    // randomised transactions, sometimes dropping active while holding
    for (int t = 0; t < 25; t++) begin
      load(1'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 2, 1'($urandom));
      accept(int'($urandom_range(0, 4)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
